// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver with internal oversampling tick, mid-cell sampling and valid/ready output.
// Define UART_RX_PARITY_EN to add a parity bit (even by default, odd with PARITY_ODD=1).

module uart_rx_oversampled #(
    parameter int CLOCK_FREQ   = 50000000,
    parameter int BAUD_RATE    = 9600,
    parameter int OVERSAMPLING = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    // state  | meaning
    // IDLE   | waiting for a tick-qualified falling edge on rx_s
    // START  | counting to mid start bit, rejecting glitches
    // DATA   | sampling 8 data bits, LSB first
    // PARITY | sampling the parity bit (parity build only)
    // STOP   | sampling the stop bit, then delivering or discarding the byte

    localparam int DIV   = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLING);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLING);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLING - 1);
    localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLING / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              rx_meta_q, rx_s_q;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              tick;
    logic              prev_s_q, prev_s_d;
    logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              stop_sample;
    logic              parity_bad;
    logic              byte_ok;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;

    // Two-flop synchroniser; resets to the idle line level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign tick = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        // prev_s tracks the line on every tick so a held-low line after a frame error never retriggers
        prev_s_d  = tick ? rx_s_q : prev_s_q;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q && prev_s_q) begin
                        state_d = S_START;
                    end
                end
                S_START: begin
                    if (os_cnt_q == OS_MID) begin
                        state_d = rx_s_q ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (os_cnt_q == OS_LAST && bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (os_cnt_q == OS_LAST) begin
                        state_d = S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (os_cnt_q == OS_LAST) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy = (state_q != S_IDLE);
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit_q, par_bit_d;
    logic parity_err_q, parity_err_d;
`endif

    always_comb begin
        os_cnt_d    = os_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d   = par_bit_q;
`endif
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    os_cnt_d = '0;
                end
                S_START: begin
                    if (os_cnt_q == OS_MID) begin
                        os_cnt_d  = '0;
                        bit_cnt_d = 3'd0;
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (os_cnt_q == OS_LAST) begin
                        shift_d   = {rx_s_q, shift_q[7:1]};
                        os_cnt_d  = '0;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (os_cnt_q == OS_LAST) begin
                        par_bit_d = rx_s_q;
                        os_cnt_d  = '0;
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (os_cnt_q == OS_LAST) begin
                        stop_sample = 1'b1;
                        os_cnt_d    = '0;
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
                default: os_cnt_d = '0;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    assign parity_bad = ((^shift_q) ^ par_bit_q) != PARITY_ODD;
`else
    assign parity_bad = 1'b0;
`endif

    // Byte delivery and handshake; a same-cycle accept frees the slot for the new byte
    always_comb begin
        byte_ok     = stop_sample && rx_s_q && !parity_bad;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q && !rx_ready;
        overrun_d   = 1'b0;
        frame_err_d = stop_sample && !rx_s_q;
        if (byte_ok) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
`ifdef UART_RX_PARITY_EN
        parity_err_d = stop_sample && parity_bad;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q   <= '0;
            prev_s_q    <= 1'b1;
            os_cnt_q    <= '0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            prev_s_q    <= prev_s_d;
            os_cnt_q    <= os_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled at DIV=10 (160 clks per bit).
module tb_uart_rx_oversampled;

    localparam int BIT_CLKS = 160;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int checks = 0;
    int errors = 0;

    int n_acc = 0, n_vcyc = 0, n_ferr = 0, n_ovr = 0, n_perr = 0;
    logic [7:0] last_acc = 8'h00;
    int b_acc, b_vcyc, b_ferr, b_ovr, b_perr;

    uart_rx_oversampled #(
        .CLOCK_FREQ  (1600000),
        .BAUD_RATE   (10000),
        .OVERSAMPLING(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (frame_err)  n_ferr <= n_ferr + 1;
        if (overrun)    n_ovr  <= n_ovr + 1;
        if (parity_err) n_perr <= n_perr + 1;
        if (rx_valid)   n_vcyc <= n_vcyc + 1;
        if (rx_valid && rx_ready) begin
            n_acc    <= n_acc + 1;
            last_acc <= rx_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic use_par, input logic par,
                              input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (use_par) send_bit(par);
        send_bit(stop);
        rx = 1'b1;
    endtask

    task automatic snap();
        b_acc  = n_acc;
        b_vcyc = n_vcyc;
        b_ferr = n_ferr;
        b_ovr  = n_ovr;
        b_perr = n_perr;
    endtask

    initial begin
        rst_n    = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b0;
        #1;
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_pulses", {29'd0, frame_err, overrun, parity_err}, 32'd0);
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(50);

        // 0xA5 accepted immediately
        rx_ready = 1'b1;
        snap();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        wait_clks(40);
        check("a5_accepts", 32'(n_acc - b_acc), 32'd1);
        check("a5_data", 32'(last_acc), 32'hA5);
        check("a5_valid_cycles", 32'(n_vcyc - b_vcyc), 32'd1);
        check("a5_flags", 32'((n_ferr - b_ferr) + (n_ovr - b_ovr) + (n_perr - b_perr)), 32'd0);
        check("a5_valid_low", 32'(rx_valid), 32'd0);

        // 0x3C then 0x81 back-to-back with no consumer
        rx_ready = 1'b0;
        snap();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        wait_clks(40);
        check("ovr_valid", 32'(rx_valid), 32'd1);
        check("ovr_data_held", 32'(rx_data), 32'h3C);
        check("ovr_pulses", 32'(n_ovr - b_ovr), 32'd1);
        check("ovr_no_ferr", 32'(n_ferr - b_ferr), 32'd0);
        rx_ready = 1'b1;
        wait_clks(3);
        check("ovr_accepts", 32'(n_acc - b_acc), 32'd1);
        check("ovr_acc_data", 32'(last_acc), 32'h3C);
        check("ovr_valid_cleared", 32'(rx_valid), 32'd0);

        // 40-clk low glitch on the idle line
        snap();
        rx = 1'b0;
        wait_clks(30);
        check("glitch_busy_high", 32'(busy), 32'd1);
        wait_clks(10);
        rx = 1'b1;
        wait_clks(150);
        check("glitch_busy_low", 32'(busy), 32'd0);
        check("glitch_no_valid", 32'(n_vcyc - b_vcyc), 32'd0);
        check("glitch_flags", 32'((n_ferr - b_ferr) + (n_ovr - b_ovr)), 32'd0);

        // 0x55 with low stop bit, then a held-low line
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(i[0] == 1'b0);
        send_bit(1'b0);
        rx = 1'b0;
        wait_clks(1000);
        check("brk_no_retrigger", 32'(busy), 32'd0);
        wait_clks(1000);
        rx = 1'b1;
        wait_clks(300);
        check("brk_ferr_once", 32'(n_ferr - b_ferr), 32'd1);
        check("brk_no_byte", 32'(n_vcyc - b_vcyc), 32'd0);
        check("brk_busy_low", 32'(busy), 32'd0);
        check("brk_data_kept", 32'(rx_data), 32'h3C);

        // Reset mid-DATA of 0xF0, then 0x0F
        snap();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        rx = 1'b0;
        wait_clks(80);
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_data", 32'(rx_data), 32'h00);
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(200);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
        wait_clks(40);
        check("rst_accepts", 32'(n_acc - b_acc), 32'd1);
        check("rst_acc_data", 32'(last_acc), 32'h0F);
        check("rst_flags", 32'((n_ferr - b_ferr) + (n_ovr - b_ovr) + (n_perr - b_perr)), 32'd0);

`ifdef UART_RX_PARITY_EN
        snap();
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        wait_clks(40);
        check("par_ok_accepts", 32'(n_acc - b_acc), 32'd1);
        check("par_ok_data", 32'(last_acc), 32'h07);
        check("par_ok_no_err", 32'(n_perr - b_perr), 32'd0);
        snap();
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        wait_clks(40);
        check("par_bad_err", 32'(n_perr - b_perr), 32'd1);
        check("par_bad_no_byte", 32'(n_acc - b_acc), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
